// File: rtl/spi_master_tx_fifo_if.sv
// Purpose: bundles the write-side and read-side handshake signals of the
//          SPI master TX FIFO so the APB front end, the FIFO and the SPI
//          shift controller can be wired with a single port.
// Signals:
//   clr_i      synchronous flush request
//   valid_i    write strobe from the APB interface
//   data_i     write data
//   ready_o    FIFO has space (not full)
//   valid_o    FIFO holds a word for the shift controller (not empty)
//   data_o     head-of-queue word
//   ready_i    shift controller consumes the head word
//   elements_o current occupancy
//   drop_o     one-cycle pulse after a write was rejected because full
// Modports: slave = FIFO side, master = producer/consumer side.
interface spi_master_tx_fifo_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 8,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
);
  logic                      clr_i;
  logic                      valid_i;
  logic [DATA_WIDTH-1:0]     data_i;
  logic                      ready_o;
  logic                      valid_o;
  logic [DATA_WIDTH-1:0]     data_o;
  logic                      ready_i;
  logic [LOG_BUFFER_DEPTH:0] elements_o;
  logic                      drop_o;

  modport slave (
    input  clr_i, valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, elements_o, drop_o
  );

  modport master (
    output clr_i, valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, elements_o, drop_o
  );
endinterface

// File: rtl/spi_master_tx_fifo.sv
// Purpose: TX data buffer between the SPI master APB interface and the SPI
//          shift controller. Words are stored in order and handed out on a
//          valid/ready handshake; occupancy is reported and writes arriving
//          while full are discarded and flagged with a one-cycle drop pulse.
// Ports:
//   HCLK     system clock, rising edge
//   HRESETn  asynchronous active-low reset
//   bus      spi_master_tx_fifo_if.slave (write, read, status and clear)
module spi_master_tx_fifo #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 8,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  spi_master_tx_fifo_if.slave   bus
);

  typedef logic [LOG_BUFFER_DEPTH-1:0] ptr_t;
  typedef logic [LOG_BUFFER_DEPTH:0]   cnt_t;

  localparam ptr_t PTR_LAST = ptr_t'(BUFFER_DEPTH - 1);
  localparam cnt_t CNT_FULL = cnt_t'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic drop_q, drop_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full/empty come only from the registered count, so ready_o never
  // depends combinationally on ready_i. Clear masks both handshakes.
  always_comb begin
    full     = (count_q == CNT_FULL);
    empty    = (count_q == '0);
    push     = bus.valid_i & ~full & ~bus.clr_i;
    pop      = bus.ready_i & ~empty & ~bus.clr_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = 1'b0;
    if (bus.clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Explicit wrap so depths that are not powers of two work.
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      drop_d = bus.valid_i & full;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is deliberately left out of reset; only pointers define content.
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.data_i;
    end
  end

  assign bus.ready_o    = ~full;
  assign bus.valid_o    = ~empty;
  assign bus.data_o     = mem[rd_ptr_q];
  assign bus.elements_o = count_q;
  assign bus.drop_o     = drop_q;

  // Pointer distance modulo depth; equals count except when full, where
  // the pointers coincide just as they do when empty.
  cnt_t ptr_span;
  always_comb begin
    if (wr_ptr_q >= rd_ptr_q) begin
      ptr_span = cnt_t'(wr_ptr_q) - cnt_t'(rd_ptr_q);
    end else begin
      ptr_span = cnt_t'(wr_ptr_q) + CNT_FULL - cnt_t'(rd_ptr_q);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      assert (full || (count_q == ptr_span));
      assert (count_q <= CNT_FULL);
    end
  end

endmodule

// File: tb/tb_spi_master_tx_fifo.sv
// Purpose: scoreboard bench for spi_master_tx_fifo (DATA_WIDTH=32, DEPTH=8).
// Stimulus records every accepted word in an expected queue and keeps a
// small occupancy/drop model; a separate monitor pops the queue whenever
// the FIFO hands a word to the consumer and compares it against data_o.
module tb_spi_master_tx_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic HCLK;
  logic HRESETn;

  spi_master_tx_fifo_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) bus ();

  spi_master_tx_fifo #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic [DW-1:0] exp_q [$];
  int            model_count;
  logic          model_drop;
  int            total;
  int            bad;

  task automatic compare(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Status outputs against the bench model, sampled after the edge.
  task automatic checkOutput();
    compare("elements", DW'(bus.elements_o), DW'(model_count));
    compare("ready_o", DW'(bus.ready_o), DW'(model_count != DEPTH));
    compare("valid_o", DW'(bus.valid_o), DW'(model_count != 0));
    compare("drop_o", DW'(bus.drop_o), DW'(model_drop));
  endtask

  // Drive one cycle of inputs, update the model for the coming edge, then
  // check the registered status right after that edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                               input logic r, input logic c);
    bit full;
    bit do_push;
    bit do_pop;
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = r;
    bus.clr_i   = c;
    full    = (model_count == DEPTH);
    do_push = !c && v && !full;
    do_pop  = !c && r && (model_count != 0);
    if (c) begin
      exp_q.delete();
      model_count = 0;
      model_drop  = 1'b0;
    end else begin
      if (do_push) exp_q.push_back(d);
      model_count = model_count + int'(do_push) - int'(do_pop);
      model_drop  = v && full;
    end
    @(posedge HCLK);
    #1;
    checkOutput();
  endtask

  // Monitor: every handshake seen before an edge must match the queue head.
  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESETn && bus.valid_o && bus.ready_i && !bus.clr_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL pop_underflow: got 0x%0h expected no word at %0t", bus.data_o, $time);
        end else begin
          compare("pop_data", bus.data_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    model_count = 0;
    model_drop  = 1'b0;
    HRESETn     = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b0;
    bus.clr_i   = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    #1;
    checkOutput();

    // Order and latency: three words, consumer stalled, then drained.
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 32'hA5A5_0000 + DW'(i), 1'b0, 1'b0);
    compare("head_after_3", bus.data_o, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Fill to full, one rejected write, then drain all eight.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h1000_0000 + DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Sustained push+pop at occupancy 4; pointers wrap several times.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h2000_0000 + DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h3000_0000 + DW'(i), 1'b1, 1'b0);

    // Full with concurrent pop and push: pop happens, push is dropped.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h4000_0000 + DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Clear with five words and a concurrent push, then a fresh push.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h5000_0000 + DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h5555_5555, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    compare("head_after_clr", bus.data_o, 32'h1234_5678);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle with data buffered.
    applyStimulus(1'b1, 32'h6000_0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h6000_0002, 1'b0, 1'b0);
    bus.valid_i = 1'b0;
    HRESETn     = 1'b0;
    exp_q.delete();
    model_count = 0;
    model_drop  = 1'b0;
    #1;
    checkOutput();
    #1;
    HRESETn = 1'b1;
    applyStimulus(1'b1, 32'h7000_0001, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    compare("scoreboard_empty", DW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
